jtdsp16_rom_fetch: RTL

//  Program-memory responder for the DSP16 ROM address unit. Takes the 16-bit PC
//  (rom_addr) each cycle and fetches the matching instruction word from external
//  ROM/SDRAM through a cs/ok handshake. Returns the word to the decoder and drives

---
 rtl/jtdsp16_rom_fetch.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/jtdsp16_rom_fetch.sv
// DSP16 program-memory fetch: small tag/data cache in front of an external cs/ok ROM port.
// Define JTDSP16_FETCH_PREFETCH_EN for a two-entry cur/nxt buffer with sequential prefetch.
module jtdsp16_rom_fetch #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rom_addr,
  output logic [DW-1:0] instr,
  output logic          instr_ok,
  output logic          fetch_stall,
  output logic [AW-1:0] ext_addr,
  output logic          ext_cs,
  input  logic [DW-1:0] ext_data,
  input  logic          ext_ok
);

  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;

  logic          state_q, state_d;
  logic          ext_cs_q, ext_cs_d;
  logic [AW-1:0] ext_addr_q, ext_addr_d;
  logic          hit;

`ifdef JTDSP16_FETCH_PREFETCH_EN

  logic [1:0]    valid_q, valid_d;
  logic [AW-1:0] tag_q [2];
  logic [AW-1:0] tag_d [2];
  logic [DW-1:0] data_q [2];
  logic [DW-1:0] data_d [2];
  logic          cur_q, cur_d;
  // Entry index owned by the outstanding transaction; absolute, so a pointer
  // toggle during BUSY still lands the data in the right slot.
  logic          tgt_q, tgt_d;
  logic          nxt;
  logic          hit_cur, hit_nxt;
  logic [AW-1:0] seq_addr;

  assign nxt      = ~cur_q;
  assign hit_cur  = valid_q[cur_q] && (tag_q[cur_q] == rom_addr);
  assign hit_nxt  = valid_q[nxt] && (tag_q[nxt] == rom_addr);
  assign hit      = hit_cur || hit_nxt;
  assign seq_addr = tag_q[cur_q] + AW'(1);
  assign instr    = hit_cur ? data_q[cur_q] : (hit_nxt ? data_q[nxt] : '0);

  always_comb begin
    state_d    = state_q;
    ext_cs_d   = ext_cs_q;
    ext_addr_d = ext_addr_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    tgt_d      = tgt_q;
    cur_d      = hit_nxt ? nxt : cur_q;
    case (state_q)
      StIdle: begin
        if (!hit) begin
          tgt_d        = cur_q;
          ext_addr_d   = rom_addr;
          ext_cs_d     = 1'b1;
          tag_d[cur_q] = rom_addr;
          valid_d[cur_q] = 1'b0;
          state_d      = StBusy;
        end else if (hit_cur && (!valid_q[nxt] || (tag_q[nxt] != seq_addr))) begin
          tgt_d        = nxt;
          ext_addr_d   = seq_addr;
          ext_cs_d     = 1'b1;
          tag_d[nxt]   = seq_addr;
          valid_d[nxt] = 1'b0;
          state_d      = StBusy;
        end
      end
      default: begin
        if (ext_ok) begin
          data_d[tgt_q]  = ext_data;
          valid_d[tgt_q] = 1'b1;
          ext_cs_d       = 1'b0;
          state_d        = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
      cur_q   <= 1'b0;
      tgt_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
    end
  end

`else

  logic          valid_q, valid_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_q, data_d;

  assign hit   = valid_q && (tag_q == rom_addr);
  assign instr = hit ? data_q : '0;

  always_comb begin
    state_d    = state_q;
    ext_cs_d   = ext_cs_q;
    ext_addr_d = ext_addr_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    case (state_q)
      StIdle: begin
        if (!hit) begin
          ext_addr_d = rom_addr;
          ext_cs_d   = 1'b1;
          tag_d      = rom_addr;
          valid_d    = 1'b0;
          state_d    = StBusy;
        end
      end
      default: begin
        if (ext_ok) begin
          data_d   = ext_data;
          valid_d  = 1'b1;
          ext_cs_d = 1'b0;
          state_d  = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

`endif

  // The request is never aborted by a PC change; only reset drops ext_cs early.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ext_cs_q   <= 1'b0;
      ext_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ext_cs_q   <= ext_cs_d;
      ext_addr_q <= ext_addr_d;
    end
  end

  assign instr_ok    = hit;
  assign fetch_stall = ~hit;
  assign ext_cs      = ext_cs_q;
  assign ext_addr    = ext_addr_q;

endmodule
